wb_port_arbiter: RTL and testbench

- Owns the single register-file write port and shares it between two requesters.
- Requester 1: the in-order pipeline result arriving from EXE_MEM.
- Requester 2: a multi-cycle unit (mul/div, uncached load) that completes at arbitrary times, using a valid/ready handshake.
- Holds one pending multi-cycle result, gives the pipeline priority, and stalls the pipeline when the held result ages out. Outputs drive Regfile directly.

---
 rtl/wb_port_arbiter_pkg.sv | 8 +
 rtl/wba_hold_buf.sv | 29 ++
 rtl/wb_port_arbiter.sv | 71 +++++++
 tb/tb_wb_port_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared state encoding for the write-back port arbiter
package wb_port_arbiter_pkg;
  typedef enum logic [1:0] {
    WBA_IDLE  = 2'b00,
    WBA_HELD  = 2'b01,
    WBA_FORCE = 2'b10
  } wba_state_t;
endpackage

// File: rtl/wba_hold_buf.sv
// wba_hold_buf: one-entry data/addr holding register for a pending multi-cycle result
module wba_hold_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr,
  output logic              valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      addr  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      addr  <= load_addr;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the regfile write port between the pipeline and a held multi-cycle result
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i_WBA,
  input  logic              rst_i_WBA,
  input  logic [DATA_W-1:0] Pipe_Data_i_WBA,
  input  logic [ADDR_W-1:0] Pipe_Addr_i_WBA,
  input  logic              Pipe_Enable_i_WBA,
  input  logic              Mc_Valid_i_WBA,
  input  logic [DATA_W-1:0] Mc_Data_i_WBA,
  input  logic [ADDR_W-1:0] Mc_Addr_i_WBA,
  output logic              Mc_Ready_o_WBA,
  output logic              Mc_Pend_o_WBA,
  output logic [ADDR_W-1:0] Mc_Pend_Addr_o_WBA,
  output logic              Stall_o_WBA,
  output logic [DATA_W-1:0] Wt_Data_o_WBA,
  output logic [ADDR_W-1:0] Wt_Addr_o_WBA,
  output logic              Wt_Enable_o_WBA
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  wba_state_t state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [DATA_W-1:0] buf_data;
  logic [ADDR_W-1:0] buf_addr;
  logic buf_valid, pipe_ok, drain, load;
  assign pipe_ok = Pipe_Enable_i_WBA && (Pipe_Addr_i_WBA != '0);
  assign drain   = (state == WBA_FORCE) || (state == WBA_HELD && !pipe_ok);
  assign load    = (state == WBA_IDLE) && Mc_Valid_i_WBA && (Mc_Addr_i_WBA != '0);
  assign cnt_inc = cnt + CNT_W'(1);
  assign Mc_Ready_o_WBA     = (state == WBA_IDLE) && !rst_i_WBA;
  assign Mc_Pend_o_WBA      = (state != WBA_IDLE) && !rst_i_WBA;
  assign Stall_o_WBA        = (state == WBA_FORCE) && !rst_i_WBA;
  assign Mc_Pend_Addr_o_WBA = Mc_Pend_o_WBA ? buf_addr : '0;
  wba_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf (
    .clk(clk_i_WBA), .rst(rst_i_WBA), .load(load), .clear(drain),
    .load_data(Mc_Data_i_WBA), .load_addr(Mc_Addr_i_WBA),
    .data(buf_data), .addr(buf_addr), .valid(buf_valid)
  );
  always_ff @(posedge clk_i_WBA) begin
    if (rst_i_WBA) begin
      state           <= WBA_IDLE;
      cnt             <= '0;
      Wt_Enable_o_WBA <= 1'b0;
      Wt_Data_o_WBA   <= '0;
      Wt_Addr_o_WBA   <= '0;
    end else begin
      Wt_Enable_o_WBA <= drain || pipe_ok;
      if (drain || pipe_ok) begin
        Wt_Data_o_WBA <= drain ? buf_data : Pipe_Data_i_WBA;
        Wt_Addr_o_WBA <= drain ? buf_addr : Pipe_Addr_i_WBA;
      end
      case (state)
        WBA_IDLE: if (load) begin
          state <= WBA_HELD;
          cnt   <= '0;
        end
        WBA_HELD: if (!pipe_ok || !buf_valid) state <= WBA_IDLE;
          else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_W'(MAX_WAIT)) state <= WBA_FORCE;
          end
        default: state <= WBA_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench comparing the arbiter against a queue-based reference model
module tb_wb_port_arbiter;
  localparam int MAX_WAIT = 4;
  logic clk = 0, rst = 1;
  logic [31:0] pipe_data = '0, mc_data = '0;
  logic [4:0] pipe_addr = '0, mc_addr = '0;
  logic pipe_en = 0, mc_valid = 0;
  logic mc_ready, mc_pend, stall, wt_en;
  logic [4:0] pend_addr, wt_addr;
  logic [31:0] wt_data;
  int compared = 0, mismatched = 0;
  typedef struct {
    bit full; bit en; logic [4:0] addr; logic [31:0] data;
    bit ready; bit pend; bit stall; logic [4:0] paddr;
  } exp_t;
  exp_t q[$];
  // reference model: an optional held result plus the number of edges it has lost
  bit m_held = 0, m_forced = 0;
  int m_losses = 0;
  logic [4:0] m_addr = '0;
  logic [31:0] m_data = '0;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i_WBA(clk), .rst_i_WBA(rst),
    .Pipe_Data_i_WBA(pipe_data), .Pipe_Addr_i_WBA(pipe_addr), .Pipe_Enable_i_WBA(pipe_en),
    .Mc_Valid_i_WBA(mc_valid), .Mc_Data_i_WBA(mc_data), .Mc_Addr_i_WBA(mc_addr),
    .Mc_Ready_o_WBA(mc_ready), .Mc_Pend_o_WBA(mc_pend), .Mc_Pend_Addr_o_WBA(pend_addr),
    .Stall_o_WBA(stall), .Wt_Data_o_WBA(wt_data), .Wt_Addr_o_WBA(wt_addr),
    .Wt_Enable_o_WBA(wt_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic step(input bit r, input bit pe, input logic [4:0] pa, input logic [31:0] pd,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md);
    exp_t e;
    bit pok;
    @(negedge clk);
    rst = r; pipe_en = pe; pipe_addr = pa; pipe_data = pd;
    mc_valid = mv; mc_addr = ma; mc_data = md;
    pok = pe && pa != 0;
    e = '{default: 0};
    e.full = r;
    if (r) begin
      m_held = 0; m_forced = 0; m_losses = 0;
    end else if (m_held && (m_forced || !pok)) begin
      e.en = 1; e.addr = m_addr; e.data = m_data;
      m_held = 0; m_forced = 0;
    end else begin
      if (pok) begin
        e.en = 1; e.addr = pa; e.data = pd;
      end
      if (m_held) begin
        m_losses++;
        if (m_losses == MAX_WAIT) m_forced = 1;
      end else if (mv && ma != 0) begin
        m_held = 1; m_losses = 0; m_addr = ma; m_data = md;
      end
    end
    e.ready = !r && !m_held;
    e.pend = !r && m_held;
    e.stall = !r && m_forced;
    e.paddr = m_held ? m_addr : 5'd0;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wt_enable", {31'd0, wt_en}, {31'd0, e.en});
        if (e.en || e.full) begin
          chk("wt_addr", {27'd0, wt_addr}, {27'd0, e.addr});
          chk("wt_data", wt_data, e.data);
        end
        chk("mc_ready", {31'd0, mc_ready}, {31'd0, e.ready});
        chk("mc_pend", {31'd0, mc_pend}, {31'd0, e.pend});
        chk("stall", {31'd0, stall}, {31'd0, e.stall});
        chk("pend_addr", {27'd0, pend_addr}, {27'd0, e.paddr});
      end
    end
  end

  initial begin
    repeat (2) step(1, 1, 5, 32'hA5A5A5A5, 1, 5, 32'h5A5A5A5A);
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    step(0, 1, 0, 32'h11111111, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 32'h12345678);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 32'h30, 1, 9, 32'h99999999);
    for (int i = 1; i <= 7; i++) step(0, 1, 3, 32'h30 + i, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 12, 32'hC0C0C0C0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) == 0, $urandom_range(9) < 7, 5'($urandom_range(31) < 4 ? 0 : $urandom),
           $urandom, $urandom_range(9) < 4, 5'($urandom_range(7) == 0 ? 0 : $urandom), $urandom);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
